depacketizer_mm2s: RTL and testbench



---
 rtl/depacketizer_mm2s_pkg.sv | 13 +
 rtl/depacketizer_mm2s_if.sv | 12 +
 rtl/depacketizer_mm2s_skid.sv | 69 ++++++
 rtl/depacketizer_mm2s.sv | 170 +++++++++++++++++
 tb/tb_depacketizer_mm2s.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/depacketizer_mm2s_pkg.sv
// Shared definitions for the MM2S depacketizer and its stream helpers.
package adc_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ERR_CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } depack_state_t;

endpackage

// File: rtl/depacketizer_mm2s_if.sv
// AXI-Stream bundle used on both sides of the depacketizer.
interface depacketizer_mm2s_if #(
  parameter int DATA_WIDTH = adc_pkg::DATA_WIDTH_DEF
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/depacketizer_mm2s_skid.sv
// Two-entry registered AXI-Stream buffer. Ready and valid both come straight
// from the occupancy register, so neither side sees a combinational path
// from the other.
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  push;
  logic                  pop;

  assign s_tready_o = (cnt_q != 2'd2);
  assign m_tvalid_o = (cnt_q != 2'd0);
  assign m_tdata_o  = head_q;
  assign push       = s_tvalid_i && s_tready_o;
  assign pop        = m_tvalid_o && m_tready_i;

  // Occupancy and slot update: head is always the word on the output.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = s_tdata_i;
        else               tail_d = s_tdata_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = s_tdata_i;
        end else begin
          head_d = tail_q;
          tail_d = s_tdata_i;
        end
      end
      default: ;
    endcase
  end

  // Buffer registers; reset empties the buffer and drops any held data.
  always_ff @(posedge aclk) begin
    if (areset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/depacketizer_mm2s.sv
// MM2S depacketizer: checks each tlast-framed DMA packet against the length
// in config_reg and forwards its payload as a continuous stream.
// Optional build macro: DEPACKETIZER_ERR_CNT_EN enables the saturating
// framing-error counter; otherwise err_count is tied to zero.
//
// state | meaning
// IDLE  | waiting for the first word of a packet (halted while config_reg == 0)
// RUN   | forwarding words, counting towards the latched length
// DRAIN | length reached without tlast; discarding until tlast
module depacketizer_mm2s
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ITER_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  depacketizer_mm2s_if.slave    s_axis_mm2s,
  depacketizer_mm2s_if.master   m_axis_data,
  input  logic [31:0]           config_reg,
  output logic [31:0]           packet_counter,
  output logic [ITER_WIDTH-1:0] iter_counter,
  output logic                  err_short,
  output logic                  err_long,
  output logic [ERR_CNT_W-1:0]  err_count
);

  depack_state_t         state_q, state_d;
  logic [31:0]           len_q, len_d;
  logic [31:0]           word_cnt_q, word_cnt_d;
  logic [31:0]           pkt_q, pkt_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic                  err_short_q, err_short_d;
  logic                  err_long_q, err_long_d;

  logic                  skid_ready;
  logic                  s_tready;
  logic                  accept;
  logic                  fwd_valid;
  logic [31:0]           cur_idx;
  logic [31:0]           cur_len;
  logic [31:0]           last_idx;

  // The first word of a packet is judged against config_reg directly, later
  // words against the length latched when the packet started.
  assign cur_idx  = (state_q == IDLE) ? 32'd0 : word_cnt_q;
  assign cur_len  = (state_q == IDLE) ? config_reg : len_q;
  assign last_idx = cur_len - 32'd1;

  // Source ready: always open while draining, gated by buffer space otherwise.
  always_comb begin
    s_tready = 1'b0;
    case (state_q)
      DRAIN:   s_tready = 1'b1;
      RUN:     s_tready = skid_ready;
      default: s_tready = (config_reg != 32'd0) && skid_ready;
    endcase
  end

  assign s_axis_mm2s.tready = s_tready;
  assign accept             = s_axis_mm2s.tvalid && s_tready;
  assign fwd_valid          = accept && (state_q != DRAIN);

  axis_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .aclk       (aclk),
    .areset     (areset),
    .s_tdata_i  (s_axis_mm2s.tdata),
    .s_tvalid_i (fwd_valid),
    .s_tready_o (skid_ready),
    .m_tdata_o  (m_axis_data.tdata),
    .m_tvalid_o (m_axis_data.tvalid),
    .m_tready_i (m_axis_data.tready)
  );

  // The output is an unframed stream.
  assign m_axis_data.tlast = 1'b0;

  // Next-state, length latch, packet/iteration counters and sticky flags.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    pkt_d       = pkt_q;
    iter_d      = iter_q;
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
    if (accept) begin
      case (state_q)
        DRAIN: begin
          if (s_axis_mm2s.tlast) begin
            iter_d  = iter_q + 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          if (state_q == IDLE) begin
            len_d = config_reg;
            pkt_d = pkt_q + 32'd1;
          end
          if (s_axis_mm2s.tlast) begin
            iter_d     = iter_q + 1'b1;
            word_cnt_d = 32'd0;
            state_d    = IDLE;
            if (cur_idx != last_idx) err_short_d = 1'b1;
          end else if (cur_idx == last_idx) begin
            err_long_d = 1'b1;
            word_cnt_d = 32'd0;
            state_d    = DRAIN;
          end else begin
            word_cnt_d = cur_idx + 32'd1;
            state_d    = RUN;
          end
        end
      endcase
    end
  end

  // Control and counter registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      len_q       <= 32'd0;
      word_cnt_q  <= 32'd0;
      pkt_q       <= 32'd0;
      iter_q      <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      pkt_q       <= pkt_d;
      iter_q      <= iter_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
    end
  end

  assign packet_counter = pkt_q;
  assign iter_counter   = iter_q;
  assign err_short      = err_short_q;
  assign err_long       = err_long_q;

`ifdef DEPACKETIZER_ERR_CNT_EN
  logic                 err_event;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign err_event = accept && (state_q != DRAIN) &&
                     (s_axis_mm2s.tlast ? (cur_idx != last_idx) : (cur_idx == last_idx));

  // Saturating count of short and long framing events.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_event && (err_cnt_q != {ERR_CNT_W{1'b1}})) err_cnt_d = err_cnt_q + 1'b1;
  end

  // Error counter register.
  always_ff @(posedge aclk) begin
    if (areset) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_depacketizer_mm2s.sv
// Directed bench for depacketizer_mm2s: packet-level vector table plus
// hand-written reset and disabled-block sequences.
module tb_depacketizer_mm2s;

`ifdef DEPACKETIZER_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        areset;
  logic [31:0] config_reg;
  logic [31:0] packet_counter;
  logic [15:0] iter_counter;
  logic        err_short;
  logic        err_long;
  logic [15:0] err_count;

  depacketizer_mm2s_if #(.DATA_WIDTH(32)) s_if ();
  depacketizer_mm2s_if #(.DATA_WIDTH(32)) m_if ();

  depacketizer_mm2s #(.DATA_WIDTH(32), .ITER_WIDTH(16)) dut (
    .aclk           (clk),
    .areset         (areset),
    .s_axis_mm2s    (s_if),
    .m_axis_data    (m_if),
    .config_reg     (config_reg),
    .packet_counter (packet_counter),
    .iter_counter   (iter_counter),
    .err_short      (err_short),
    .err_long       (err_long),
    .err_count      (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } src_t;

  typedef struct {
    logic [31:0] cfg;
    int          n_pkt;
    int          len_first;
    int          len_rest;
    bit          bp;
    bit          chk_gap;
    int          exp_fwd;
    int          exp_pkt;
    int          exp_iter;
    bit          exp_short;
    bit          exp_long;
    int          exp_errc;
  } vec_t;

  int          checks;
  int          errors;
  src_t        src_q[$];
  logic [31:0] rx_q[$];
  logic [31:0] exp_q[$];
  bit          src_hs;
  int          src_acc;
  bit          m_bp;
  int          cyc;
  int          first_rx_cyc;
  int          last_rx_cyc;
  bit          stall_prev;
  logic [31:0] stall_data;
  vec_t        vecs[6];

  // Source: presents the queue head; a word leaves the queue once it was taken.
  always @(negedge clk) begin
    src_t drop;
    if (areset) begin
      src_hs      = 1'b0;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      s_if.tdata  = '0;
    end else begin
      if (src_hs && src_q.size() > 0) begin
        drop = src_q.pop_front();
        src_acc++;
      end
      if (src_q.size() > 0) begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = src_q[0].data;
        s_if.tlast  = src_q[0].last;
      end else begin
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
      end
      src_hs = s_if.tvalid && s_if.tready;
    end
  end

  // Sink: drives ready, records transfers, checks data holds while stalled.
  always @(negedge clk) begin
    cyc++;
    m_if.tready = m_bp ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (!areset) begin
      if (stall_prev) begin
        checks++;
        if (!m_if.tvalid || m_if.tdata !== stall_data) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b data=%08h required valid=1 data=%08h",
                   m_if.tvalid, m_if.tdata, stall_data);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        if (rx_q.size() == 0) first_rx_cyc = cyc;
        last_rx_cyc = cyc;
        rx_q.push_back(m_if.tdata);
      end
      stall_prev = m_if.tvalid && !m_if.tready;
      stall_data = m_if.tdata;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cmp_rx(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      if (bad < 0 && rx_q[i] !== exp_q[i]) bad = i;
    checks++;
    if (rx_q.size() != exp_q.size() || bad >= 0) begin
      errors++;
      $display("FAIL %s: got %0d words (first bad index %0d) required %0d words in order",
               name, rx_q.size(), bad, exp_q.size());
    end
  endtask

  task automatic start_reset(input logic [31:0] cfg, input bit bp);
    @(posedge clk); #2;
    areset     = 1'b1;
    config_reg = cfg;
    m_bp       = bp;
    src_q.delete();
    rx_q.delete();
    exp_q.delete();
    first_rx_cyc = -1;
    last_rx_cyc  = -1;
    src_acc      = 0;
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((src_q.size() != 0 || s_if.tvalid) && n < 3000) begin
      @(posedge clk); #2; n++;
    end
    while (m_if.tvalid && n < 3300) begin
      @(posedge clk); #2; n++;
    end
    repeat (2) @(posedge clk);
    #2;
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d cycles with traffic pending required completion", name, n);
    end
  endtask

  initial begin
    int rdy_cnt;
    int mv_cnt;
    int n;
    int len;
    logic [31:0] w;
    checks     = 0;
    errors     = 0;
    areset     = 1'b1;
    config_reg = 32'd0;
    m_bp       = 1'b0;
    cyc        = 0;
    stall_prev = 1'b0;

    //             cfg  n  first rest bp gap fwd pkt iter sh lo errc
    vecs[0] = '{32'd10, 3, 10, 10, 1'b0, 1'b1, 30, 3, 3, 1'b0, 1'b0, 0};
    vecs[1] = '{32'd10, 1,  6, 10, 1'b0, 1'b0,  6, 1, 1, 1'b1, 1'b0, 1};
    vecs[2] = '{32'd10, 2, 14, 10, 1'b0, 1'b0, 20, 2, 2, 1'b0, 1'b1, 1};
    vecs[3] = '{32'd1,  4,  1,  1, 1'b0, 1'b1,  4, 4, 4, 1'b0, 1'b0, 0};
    vecs[4] = '{32'd3,  2,  2,  5, 1'b0, 1'b0,  5, 2, 2, 1'b1, 1'b1, 2};
    vecs[5] = '{32'd10, 5, 10, 10, 1'b1, 1'b0, 50, 5, 5, 1'b0, 1'b0, 0};

    // Reset state and disabled block (config_reg == 0) with the source valid.
    start_reset(32'd0, 1'b0);
    for (int i = 0; i < 5; i++) src_q.push_back('{32'h0D00_0000 + i, (i == 4)});
    areset = 1'b0;
    chk("rst_s_tready", s_if.tready, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_packet_counter", packet_counter, 0);
    chk("rst_iter_counter", iter_counter, 0);
    chk("rst_err_flags", {err_short, err_long}, 0);
    chk("rst_err_count", err_count, 0);
    rdy_cnt = 0;
    mv_cnt  = 0;
    repeat (20) begin
      @(posedge clk); #2;
      if (s_if.tready) rdy_cnt++;
      if (m_if.tvalid) mv_cnt++;
    end
    chk("cfg0_src_valid", s_if.tvalid, 1);
    chk("cfg0_tready_cycles", rdy_cnt, 0);
    chk("cfg0_m_valid_cycles", mv_cnt, 0);
    chk("cfg0_packet_counter", packet_counter, 0);
    chk("cfg0_iter_counter", iter_counter, 0);

    // Packet-level vectors.
    for (int v = 0; v < 6; v++) begin
      start_reset(vecs[v].cfg, vecs[v].bp);
      for (int p = 0; p < vecs[v].n_pkt; p++) begin
        len = (p == 0) ? vecs[v].len_first : vecs[v].len_rest;
        for (int i = 0; i < len; i++) begin
          w = {8'hA5, 8'(v), 8'(p), 8'(i)};
          src_q.push_back('{w, (i == len - 1)});
          if (i < int'(vecs[v].cfg)) exp_q.push_back(w);
        end
      end
      areset = 1'b0;
      wait_done($sformatf("v%0d", v));
      chk($sformatf("v%0d_fwd_count", v), rx_q.size(), vecs[v].exp_fwd);
      cmp_rx($sformatf("v%0d_fwd_data", v));
      chk($sformatf("v%0d_packet_counter", v), packet_counter, vecs[v].exp_pkt);
      chk($sformatf("v%0d_iter_counter", v), iter_counter, vecs[v].exp_iter);
      chk($sformatf("v%0d_err_short", v), err_short, vecs[v].exp_short);
      chk($sformatf("v%0d_err_long", v), err_long, vecs[v].exp_long);
      chk($sformatf("v%0d_err_count", v), err_count, ERR_EN ? vecs[v].exp_errc : 0);
      if (vecs[v].chk_gap)
        chk($sformatf("v%0d_no_bubble", v), last_rx_cyc - first_rx_cyc, vecs[v].exp_fwd - 1);
    end

    // Reset in the middle of a packet, then a clean packet.
    start_reset(32'd10, 1'b0);
    for (int i = 0; i < 10; i++) src_q.push_back('{32'hB000_0000 + i, (i == 9)});
    areset = 1'b0;
    n = 0;
    while (src_acc < 5 && n < 200) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL midrst_timeout: got %0d words accepted required 5", src_acc);
    end
    areset = 1'b1;
    src_q.delete();
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      src_q.push_back('{32'hC000_0000 + i, (i == 9)});
      exp_q.push_back(32'hC000_0000 + i);
    end
    repeat (3) @(posedge clk);
    #2;
    chk("midrst_packet_counter", packet_counter, 0);
    chk("midrst_iter_counter", iter_counter, 0);
    chk("midrst_m_tvalid", m_if.tvalid, 0);
    areset = 1'b0;
    wait_done("midrst");
    chk("midrst_fwd_count", rx_q.size(), 10);
    cmp_rx("midrst_fwd_data");
    chk("midrst_packet_after", packet_counter, 1);
    chk("midrst_iter_after", iter_counter, 1);
    chk("midrst_err_flags", {err_short, err_long}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
